hwpe_ctrl_ctx_queue: RTL and testbench
======================================

Name: hwpe_ctrl_ctx_queue

Overview:
Parametrised job-context manager for the HWPE control slave. It generalises the fixed two-context acquire/trigger/finish scheme to N contexts handled as a circular queue, and adds per-core ownership, trigger-source checking and a finished-job counter. It sits between the register-file bus decoder (acquire/trigger accesses) and the engine (start/done handshake), and drives the per-core completion events.

Parameters:
N_CONTEXT, 4, number of job contexts; power of two, ≥2
N_CORES, 16, number of offloading cores; sizes the source IDs and the event vector
CNT_WIDTH, 32, width of the finished-job counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
clear_i  in  1  synchronous soft clear; same effect as reset
acquire_i  in  1  acquire access strobe; one per cycle
acquire_src_i  in  $clog2(N_CORES)  requesting core ID
acquire_rvalid_o  out  1  acquire response valid pulse
acquire_rdata_o  out  32  context ID, or 0xFFFF_FFFF on failure
trigger_i  in  1  trigger access strobe
trigger_src_i  in  $clog2(N_CORES)  triggering core ID
trigger_err_o  out  1  trigger rejected pulse
start_o  out  1  engine start, 1-cycle pulse
done_i  in  1  engine done pulse
running_ctx_o  out  $clog2(N_CONTEXT)  context running, or last run
pointer_ctx_o  out  $clog2(N_CONTEXT)  next context to allocate
busy_o  out  N_CONTEXT  bit i high when context i is not FREE
is_working_o  out  1  engine FSM is in START or RUNNING
evt_o  out  N_CORES  one-hot completion event to the owning core, 1-cycle pulse
finished_cnt_o  out  CNT_WIDTH  jobs completed since reset or clear

Behaviour:
- Per-context state is one of FREE, ACQUIRED, QUEUED, RUNNING, plus a stored owner ID.
  - Allocation pointer (alloc) and execution pointer (exec) wrap modulo N_CONTEXT.
  - Contexts are allocated and executed strictly in ring order.
- At most one context may be ACQUIRED at a time.
- Acquire, evaluated on the state at the start of the cycle (no bypass):
  - Succeeds if no context is ACQUIRED and ctx[alloc] is FREE.
  - On success: ctx[alloc] becomes ACQUIRED, owner is set to acquire_src_i, and alloc increments.
  - acquire_rvalid_o pulses the next cycle. acquire_rdata_o carries the zero-extended context ID, or 0xFFFF_FFFF if the ring is full or the lock is held. rdata holds until the next acquire.
- Trigger:
  - If a context is ACQUIRED and trigger_src_i equals its owner, that context becomes QUEUED.
  - Otherwise no state change, and trigger_err_o pulses the next cycle.
- Engine FSM has three states: IDLE, START, RUNNING.
  - IDLE→START when ctx[exec] is QUEUED; in START, start_o=1 and running_ctx_o=exec.
  - START→RUNNING unconditionally, and ctx[exec] becomes RUNNING.
  - RUNNING→IDLE on done_i: ctx[exec] becomes FREE, exec increments, finished_cnt_o increments (wraps at 2^CNT_WIDTH), and evt_o[owner] pulses the next cycle.
  - done_i in IDLE or START is ignored.
- Latency:
  - Trigger sampled in cycle 0 → start_o in cycle 2.
  - done_i in cycle k with a further QUEUED context → start_o in cycle k+2.
  - Idle-to-idle back-to-back: one bubble cycle.
- Simultaneous events: acquire, trigger and done in the same cycle are all evaluated on pre-cycle state.
  - A context freed by done_i is not allocatable in the same cycle.
  - Acquire together with a valid trigger fails (lock still held).
- Reset or clear_i:
  - All contexts FREE; alloc=exec=0; FSM IDLE; counter=0.
  - Every output is 0 except acquire_rdata_o=0.
  - Pending responses and events in flight are discarded.
  - Clear overrides every same-cycle event.
- busy_o and pointer_ctx_o reflect registered state, with no combinational path from inputs.

Test Plan:
- Reset, then core 3 acquires → rdata=0, busy_o=0001; trigger src 3 in cycle 10 → start_o at cycle 12; done_i → evt_o=0x0008, finished_cnt_o=1, busy_o=0000.
- Full ring: N_CONTEXT=4; four acquire/trigger pairs with the engine held RUNNING → IDs 0,1,2,3. Fifth acquire → 0xFFFF_FFFF. After one done, next acquire → 0 (wrap).
- Lock: core 1 acquires (ID 0) and core 2 acquires before any trigger → 0xFFFF_FFFF. Trigger from core 2 → trigger_err_o=1, no state change; trigger from core 1 → QUEUED.
- Back-to-back: contexts 0 and 1 QUEUED; done_i at cycle 20 → start_o at cycle 22, running_ctx_o=1, evt_o to the owner of context 0 at cycle 21.
- Same-cycle: ring full, done_i and acquire_i together → acquire fails; a repeat acquire next cycle → succeeds with the freed ID.
- Clear mid-run: clear_i while RUNNING with 2 QUEUED → busy_o=0, is_working_o=0, counter=0. A later done_i is ignored; no evt_o.

Source files
------------

// File: rtl/hwpe_ctrl_ctx_queue_if.sv
// Bus/engine-side signals of the job-context queue, grouped so the decoder,
// engine and event fabric connect through one bundle.
interface hwpe_ctrl_ctx_queue_if #(
   parameter int unsigned N_CONTEXT = 4,
   parameter int unsigned N_CORES   = 16,
   parameter int unsigned CNT_WIDTH = 32
);
   localparam int unsigned CTX_W = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
   localparam int unsigned SRC_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   logic                 acquire_i;
   logic [SRC_W-1:0]     acquire_src_i;
   logic                 acquire_rvalid_o;
   logic [31:0]          acquire_rdata_o;
   logic                 trigger_i;
   logic [SRC_W-1:0]     trigger_src_i;
   logic                 trigger_err_o;
   logic                 start_o;
   logic                 done_i;
   logic [CTX_W-1:0]     running_ctx_o;
   logic [CTX_W-1:0]     pointer_ctx_o;
   logic [N_CONTEXT-1:0] busy_o;
   logic                 is_working_o;
   logic [N_CORES-1:0]   evt_o;
   logic [CNT_WIDTH-1:0] finished_cnt_o;

   modport master (
      output acquire_i, acquire_src_i, trigger_i, trigger_src_i, done_i,
      input  acquire_rvalid_o, acquire_rdata_o, trigger_err_o, start_o,
             running_ctx_o, pointer_ctx_o, busy_o, is_working_o, evt_o,
             finished_cnt_o
   );

   modport slave (
      input  acquire_i, acquire_src_i, trigger_i, trigger_src_i, done_i,
      output acquire_rvalid_o, acquire_rdata_o, trigger_err_o, start_o,
             running_ctx_o, pointer_ctx_o, busy_o, is_working_o, evt_o,
             finished_cnt_o
   );
endinterface

// File: rtl/hwpe_ctrl_ctx_queue.sv
// N-context circular job queue: acquire/trigger ownership checks, engine
// start/done sequencing, per-core completion events and a finished-job counter.
module hwpe_ctrl_ctx_queue #(
   parameter int unsigned N_CONTEXT = 4,
   parameter int unsigned N_CORES   = 16,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   hwpe_ctrl_ctx_queue_if.slave  bus
);
   localparam int unsigned CTX_W = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
   localparam int unsigned SRC_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   typedef enum logic [1:0] {
      CTX_FREE, CTX_ACQUIRED, CTX_QUEUED, CTX_RUNNING
   } ctx_state_e;

   typedef enum logic [1:0] {
      ENG_IDLE, ENG_START, ENG_RUNNING
   } eng_state_e;

   ctx_state_e           r_ctx       [N_CONTEXT];
   ctx_state_e           w_ctx_nxt   [N_CONTEXT];
   logic [SRC_W-1:0]     r_owner     [N_CONTEXT];
   logic [SRC_W-1:0]     w_owner_nxt [N_CONTEXT];
   logic [CTX_W-1:0]     r_alloc, w_alloc_nxt;
   logic [CTX_W-1:0]     r_exec, w_exec_nxt;
   logic [CTX_W-1:0]     r_running, w_running_nxt;
   logic [CTX_W-1:0]     w_last;
   eng_state_e           r_eng, w_eng_nxt;

   logic                 r_acq_rvalid;
   logic [31:0]          r_acq_rdata;
   logic                 r_trig_err;
   logic [N_CORES-1:0]   r_evt;
   logic [CNT_WIDTH-1:0] r_cnt;

   logic                 w_lock_held;
   logic                 w_acq_ok;
   logic                 w_trig_ok;
   logic                 w_done_ok;
   logic [N_CONTEXT-1:0] w_busy;

   // The only context that can be ACQUIRED is the one allocated last.
   assign w_last = r_alloc - CTX_W'(1);

   always_comb begin
      w_lock_held = 1'b0;
      w_busy      = '0;
      for (int unsigned i = 0; i < N_CONTEXT; i++) begin
         if (r_ctx[i] == CTX_ACQUIRED) w_lock_held = 1'b1;
         w_busy[i] = (r_ctx[i] != CTX_FREE);
      end
   end

   assign w_acq_ok  = bus.acquire_i && !w_lock_held && (r_ctx[r_alloc] == CTX_FREE);
   assign w_trig_ok = bus.trigger_i && (r_ctx[w_last] == CTX_ACQUIRED) &&
                      (r_owner[w_last] == bus.trigger_src_i);
   assign w_done_ok = bus.done_i && (r_eng == ENG_RUNNING);

   // Acquire, trigger and engine updates always touch distinct contexts,
   // so they can be merged into one next-state array without priority.
   always_comb begin
      for (int unsigned i = 0; i < N_CONTEXT; i++) begin
         w_ctx_nxt[i]   = r_ctx[i];
         w_owner_nxt[i] = r_owner[i];
      end
      w_alloc_nxt   = r_alloc;
      w_exec_nxt    = r_exec;
      w_running_nxt = r_running;
      w_eng_nxt     = r_eng;

      if (w_acq_ok) begin
         w_ctx_nxt[r_alloc]   = CTX_ACQUIRED;
         w_owner_nxt[r_alloc] = bus.acquire_src_i;
         w_alloc_nxt          = r_alloc + CTX_W'(1);
      end

      if (w_trig_ok) begin
         w_ctx_nxt[w_last] = CTX_QUEUED;
      end

      case (r_eng)
         ENG_IDLE: begin
            if (r_ctx[r_exec] == CTX_QUEUED) begin
               w_eng_nxt     = ENG_START;
               w_running_nxt = r_exec;
            end
         end
         ENG_START: begin
            w_eng_nxt         = ENG_RUNNING;
            w_ctx_nxt[r_exec] = CTX_RUNNING;
         end
         ENG_RUNNING: begin
            if (bus.done_i) begin
               w_eng_nxt         = ENG_IDLE;
               w_ctx_nxt[r_exec] = CTX_FREE;
               w_exec_nxt        = r_exec + CTX_W'(1);
            end
         end
         default: w_eng_nxt = ENG_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            r_ctx[i]   <= CTX_FREE;
            r_owner[i] <= '0;
         end
         r_alloc      <= '0;
         r_exec       <= '0;
         r_running    <= '0;
         r_eng        <= ENG_IDLE;
         r_acq_rvalid <= 1'b0;
         r_acq_rdata  <= '0;
         r_trig_err   <= 1'b0;
         r_evt        <= '0;
         r_cnt        <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            r_ctx[i]   <= w_ctx_nxt[i];
            r_owner[i] <= w_owner_nxt[i];
         end
         r_alloc      <= w_alloc_nxt;
         r_exec       <= w_exec_nxt;
         r_running    <= w_running_nxt;
         r_eng        <= w_eng_nxt;
         r_acq_rvalid <= bus.acquire_i;
         if (bus.acquire_i) begin
            r_acq_rdata <= w_acq_ok ? 32'(r_alloc) : '1;
         end
         r_trig_err <= bus.trigger_i && !w_trig_ok;
         r_evt      <= w_done_ok ? (N_CORES'(1) << r_owner[r_exec]) : '0;
         if (w_done_ok) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.acquire_rvalid_o = r_acq_rvalid;
   assign bus.acquire_rdata_o  = r_acq_rdata;
   assign bus.trigger_err_o    = r_trig_err;
   assign bus.start_o          = (r_eng == ENG_START);
   assign bus.running_ctx_o    = r_running;
   assign bus.pointer_ctx_o    = r_alloc;
   assign bus.busy_o           = w_busy;
   assign bus.is_working_o     = (r_eng != ENG_IDLE);
   assign bus.evt_o            = r_evt;
   assign bus.finished_cnt_o   = r_cnt;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_queue.sv
// Directed self-checking bench for hwpe_ctrl_ctx_queue (N_CONTEXT=4, N_CORES=16).
module tb_hwpe_ctrl_ctx_queue;
   logic clk_i = 1'b0;
   logic rst_ni;
   logic clear_i;
   int   total = 0;
   int   bad   = 0;

   hwpe_ctrl_ctx_queue_if #(.N_CONTEXT(4), .N_CORES(16), .CNT_WIDTH(32)) bus ();

   hwpe_ctrl_ctx_queue #(.N_CONTEXT(4), .N_CORES(16), .CNT_WIDTH(32)) u_dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      bus.acquire_i     = 1'b0;
      bus.acquire_src_i = '0;
      bus.trigger_i     = 1'b0;
      bus.trigger_src_i = '0;
      bus.done_i        = 1'b0;
      clear_i           = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic acquire(input logic [3:0] src);
      bus.acquire_i     = 1'b1;
      bus.acquire_src_i = src;
      tick();
      bus.acquire_i     = 1'b0;
   endtask

   task automatic trigger(input logic [3:0] src);
      bus.trigger_i     = 1'b1;
      bus.trigger_src_i = src;
      tick();
      bus.trigger_i     = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.busy_o !== 4'b0000) begin bad++; $display("FAIL reset_busy got=%b want=0000", bus.busy_o); end
      total++; if (bus.acquire_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.acquire_rdata_o); end
      total++; if ({bus.acquire_rvalid_o, bus.trigger_err_o, bus.start_o, bus.is_working_o} !== 4'b0000)
         begin bad++; $display("FAIL reset_flags got=%b want=0000", {bus.acquire_rvalid_o, bus.trigger_err_o, bus.start_o, bus.is_working_o}); end
      total++; if (bus.evt_o !== 16'h0) begin bad++; $display("FAIL reset_evt got=%h want=0", bus.evt_o); end
      total++; if (bus.finished_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.finished_cnt_o); end
      total++; if ({bus.pointer_ctx_o, bus.running_ctx_o} !== 4'b0000)
         begin bad++; $display("FAIL reset_ptrs got=%b want=0000", {bus.pointer_ctx_o, bus.running_ctx_o}); end
   endtask

   task automatic test_single_job();
      do_reset();
      acquire(4'd3);
      total++; if (bus.acquire_rvalid_o !== 1'b1) begin bad++; $display("FAIL single_rvalid got=%b want=1", bus.acquire_rvalid_o); end
      total++; if (bus.acquire_rdata_o !== 32'h0) begin bad++; $display("FAIL single_rdata got=%h want=0", bus.acquire_rdata_o); end
      total++; if (bus.busy_o !== 4'b0001) begin bad++; $display("FAIL single_busy got=%b want=0001", bus.busy_o); end
      total++; if (bus.pointer_ctx_o !== 2'd1) begin bad++; $display("FAIL single_ptr got=%0d want=1", bus.pointer_ctx_o); end
      trigger(4'd3);
      total++; if ({bus.trigger_err_o, bus.start_o, bus.acquire_rvalid_o} !== 3'b000)
         begin bad++; $display("FAIL single_trig_cyc1 got=%b want=000", {bus.trigger_err_o, bus.start_o, bus.acquire_rvalid_o}); end
      tick();
      total++; if ({bus.start_o, bus.is_working_o} !== 2'b11) begin bad++; $display("FAIL single_start got=%b want=11", {bus.start_o, bus.is_working_o}); end
      total++; if (bus.running_ctx_o !== 2'd0) begin bad++; $display("FAIL single_running got=%0d want=0", bus.running_ctx_o); end
      tick();
      total++; if ({bus.start_o, bus.is_working_o} !== 2'b01) begin bad++; $display("FAIL single_run got=%b want=01", {bus.start_o, bus.is_working_o}); end
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      total++; if (bus.evt_o !== 16'h0008) begin bad++; $display("FAIL single_evt got=%h want=0008", bus.evt_o); end
      total++; if (bus.finished_cnt_o !== 32'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", bus.finished_cnt_o); end
      total++; if ({bus.busy_o, bus.is_working_o} !== 5'b00000) begin bad++; $display("FAIL single_free got=%b want=00000", {bus.busy_o, bus.is_working_o}); end
      tick();
      total++; if (bus.evt_o !== 16'h0) begin bad++; $display("FAIL single_evt_pulse got=%h want=0", bus.evt_o); end
   endtask

   task automatic test_full_ring();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         acquire(4'(i + 4));
         total++; if (bus.acquire_rdata_o !== 32'(i)) begin bad++; $display("FAIL ring_id%0d got=%h want=%h", i, bus.acquire_rdata_o, 32'(i)); end
         trigger(4'(i + 4));
      end
      total++; if ({bus.busy_o, bus.pointer_ctx_o} !== 6'b111100) begin bad++; $display("FAIL ring_busy_ptr got=%b want=111100", {bus.busy_o, bus.pointer_ctx_o}); end
      total++; if ({bus.is_working_o, bus.start_o} !== 2'b10) begin bad++; $display("FAIL ring_running got=%b want=10", {bus.is_working_o, bus.start_o}); end
      acquire(4'd9);
      total++; if ({bus.acquire_rvalid_o, bus.acquire_rdata_o} !== {1'b1, 32'hFFFF_FFFF})
         begin bad++; $display("FAIL ring_full got=%b_%h want=1_ffffffff", bus.acquire_rvalid_o, bus.acquire_rdata_o); end
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      total++; if (bus.evt_o !== 16'h0010) begin bad++; $display("FAIL ring_evt got=%h want=0010", bus.evt_o); end
      acquire(4'd9);
      total++; if (bus.acquire_rdata_o !== 32'h0) begin bad++; $display("FAIL ring_wrap got=%h want=0", bus.acquire_rdata_o); end
      total++; if (bus.pointer_ctx_o !== 2'd1) begin bad++; $display("FAIL ring_wrap_ptr got=%0d want=1", bus.pointer_ctx_o); end
   endtask

   task automatic test_lock();
      do_reset();
      acquire(4'd1);
      total++; if (bus.acquire_rdata_o !== 32'h0) begin bad++; $display("FAIL lock_first got=%h want=0", bus.acquire_rdata_o); end
      acquire(4'd2);
      total++; if (bus.acquire_rdata_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL lock_second got=%h want=ffffffff", bus.acquire_rdata_o); end
      total++; if (bus.pointer_ctx_o !== 2'd1) begin bad++; $display("FAIL lock_ptr got=%0d want=1", bus.pointer_ctx_o); end
      trigger(4'd2);
      total++; if (bus.trigger_err_o !== 1'b1) begin bad++; $display("FAIL lock_trig_err got=%b want=1", bus.trigger_err_o); end
      tick();
      total++; if ({bus.trigger_err_o, bus.start_o, bus.is_working_o, bus.busy_o} !== 7'b0000001)
         begin bad++; $display("FAIL lock_nochange got=%b want=0000001", {bus.trigger_err_o, bus.start_o, bus.is_working_o, bus.busy_o}); end
      trigger(4'd1);
      total++; if (bus.trigger_err_o !== 1'b0) begin bad++; $display("FAIL lock_trig_ok got=%b want=0", bus.trigger_err_o); end
      tick();
      total++; if (bus.start_o !== 1'b1) begin bad++; $display("FAIL lock_start got=%b want=1", bus.start_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      acquire(4'd5);
      trigger(4'd5);
      acquire(4'd9);
      trigger(4'd9);
      tick();
      total++; if ({bus.is_working_o, bus.start_o, bus.running_ctx_o} !== 4'b1000)
         begin bad++; $display("FAIL b2b_running got=%b want=1000", {bus.is_working_o, bus.start_o, bus.running_ctx_o}); end
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      total++; if (bus.evt_o !== 16'h0020) begin bad++; $display("FAIL b2b_evt got=%h want=0020", bus.evt_o); end
      total++; if ({bus.start_o, bus.is_working_o} !== 2'b00) begin bad++; $display("FAIL b2b_bubble got=%b want=00", {bus.start_o, bus.is_working_o}); end
      tick();
      total++; if ({bus.start_o, bus.running_ctx_o} !== 3'b101) begin bad++; $display("FAIL b2b_start got=%b want=101", {bus.start_o, bus.running_ctx_o}); end
      total++; if (bus.evt_o !== 16'h0) begin bad++; $display("FAIL b2b_evt_pulse got=%h want=0", bus.evt_o); end
      tick();
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      total++; if ({bus.evt_o, bus.finished_cnt_o} !== {16'h0200, 32'd2})
         begin bad++; $display("FAIL b2b_second got=%h_%0d want=0200_2", bus.evt_o, bus.finished_cnt_o); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         acquire(4'd2);
         trigger(4'd2);
      end
      bus.done_i        = 1'b1;
      bus.acquire_i     = 1'b1;
      bus.acquire_src_i = 4'd6;
      tick();
      bus.done_i    = 1'b0;
      bus.acquire_i = 1'b0;
      total++; if ({bus.acquire_rvalid_o, bus.acquire_rdata_o} !== {1'b1, 32'hFFFF_FFFF})
         begin bad++; $display("FAIL same_done_acq got=%b_%h want=1_ffffffff", bus.acquire_rvalid_o, bus.acquire_rdata_o); end
      total++; if ({bus.evt_o, bus.busy_o} !== {16'h0004, 4'b1110}) begin bad++; $display("FAIL same_done_evt got=%h_%b want=0004_1110", bus.evt_o, bus.busy_o); end
      acquire(4'd6);
      total++; if (bus.acquire_rdata_o !== 32'h0) begin bad++; $display("FAIL same_retry got=%h want=0", bus.acquire_rdata_o); end
      do_reset();
      acquire(4'd1);
      bus.trigger_i     = 1'b1;
      bus.trigger_src_i = 4'd1;
      acquire(4'd4);
      bus.trigger_i     = 1'b0;
      total++; if ({bus.acquire_rdata_o, bus.trigger_err_o} !== {32'hFFFF_FFFF, 1'b0})
         begin bad++; $display("FAIL same_trig_acq got=%h_%b want=ffffffff_0", bus.acquire_rdata_o, bus.trigger_err_o); end
      acquire(4'd4);
      total++; if (bus.acquire_rdata_o !== 32'h1) begin bad++; $display("FAIL same_trig_retry got=%h want=1", bus.acquire_rdata_o); end
   endtask

   task automatic test_clear();
      do_reset();
      acquire(4'd7);
      trigger(4'd7);
      tick();
      tick();
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         acquire(4'd8);
         trigger(4'd8);
      end
      total++; if ({bus.finished_cnt_o, bus.is_working_o, bus.busy_o} !== {32'd1, 1'b1, 4'b1110})
         begin bad++; $display("FAIL clear_pre got=%0d_%b_%b want=1_1_1110", bus.finished_cnt_o, bus.is_working_o, bus.busy_o); end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      total++; if ({bus.busy_o, bus.is_working_o, bus.start_o, bus.pointer_ctx_o} !== 8'b0)
         begin bad++; $display("FAIL clear_state got=%b want=00000000", {bus.busy_o, bus.is_working_o, bus.start_o, bus.pointer_ctx_o}); end
      total++; if ({bus.finished_cnt_o, bus.acquire_rdata_o} !== 64'h0)
         begin bad++; $display("FAIL clear_cnt_rdata got=%0d_%h want=0_0", bus.finished_cnt_o, bus.acquire_rdata_o); end
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      tick();
      total++; if ({bus.evt_o, bus.finished_cnt_o} !== 48'h0) begin bad++; $display("FAIL clear_done_ignored got=%h_%0d want=0_0", bus.evt_o, bus.finished_cnt_o); end
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      test_reset();
      test_single_job();
      test_full_ring();
      test_lock();
      test_back_to_back();
      test_same_cycle();
      test_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
